// File: rtl/seq_mult_mxn.sv
// Sequential shift-add multiplier: M-bit x N-bit -> (M+N)-bit product using one
// (M+1)-bit adder over N cycles, with unsigned or two's-complement operands.
module seq_mult_mxn #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [M-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   P
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [M-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [M:0]     acc;
    logic [CW-1:0]  count;
    logic           neg;

    logic [M:0]     sum;
    logic [M+N:0]   shifted;

    // Signed operands are multiplied as magnitudes; the most-negative value
    // still fits as an unsigned M-bit (or N-bit) magnitude.
    function automatic logic [M-1:0] mag_a(input logic [M-1:0] v, input logic s);
        logic [M-1:0] nv;
        nv = -v;
        return (s && v[M-1]) ? nv : v;
    endfunction

    function automatic logic [N-1:0] mag_b(input logic [N-1:0] v, input logic s);
        logic [N-1:0] nv;
        nv = -v;
        return (s && v[N-1]) ? nv : v;
    endfunction

    function automatic logic [M+N-1:0] apply_sign(input logic [M+N-1:0] v, input logic n);
        logic [M+N-1:0] nv;
        nv = -v;
        return n ? nv : v;
    endfunction

    always_comb begin
        sum     = acc + (mplier[0] ? {1'b0, mcand} : '0);
        shifted = {sum, mplier} >> 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            P      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= mag_a(A, sgn);
                        mplier <= mag_b(B, sgn);
                        neg    <= sgn & (A[M-1] ^ B[N-1]);
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= shifted[M+N:N];
                    mplier <= shifted[N-1:0];
                    count  <= count + 1'b1;
                    // Last iteration: the low M+N bits of the shifted pair are the magnitude.
                    if (count == CW'(N - 1)) begin
                        P     <= apply_sign(shifted[M+N-1:0], neg);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_mxn.sv
// Scoreboard bench for seq_mult_mxn: three instances (4x4, 4x8, 8x8), directed
// vectors with hand-computed products plus a randomized regression.
module tb_seq_mult_mxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic sg0 = 1'b0, sg1 = 1'b0, sg2 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0;
    logic [7:0] b1 = '0, a2 = '0, b2 = '0;
    logic busy0, busy1, busy2, dn0, dn1, dn2;
    logic [7:0]  p0;
    logic [11:0] p1;
    logic [15:0] p2;

    seq_mult_mxn #(.M(4), .N(4)) dut0 (
        .clk(clk), .reset(reset), .start(st0), .sgn(sg0), .A(a0), .B(b0),
        .busy(busy0), .done(dn0), .P(p0));
    seq_mult_mxn #(.M(4), .N(8)) dut1 (
        .clk(clk), .reset(reset), .start(st1), .sgn(sg1), .A(a1), .B(b1),
        .busy(busy1), .done(dn1), .P(p1));
    seq_mult_mxn #(.M(8), .N(8)) dut2 (
        .clk(clk), .reset(reset), .start(st2), .sgn(sg2), .A(a2), .B(b2),
        .busy(busy2), .done(dn2), .P(p2));

    typedef struct {
        logic [15:0] exp;
        int          edge_no;
        int          id;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    item_t q2[$];
    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int mw(int d);
        return (d == 2) ? 8 : 4;
    endfunction

    function automatic int nw(int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic logic [15:0] pget(int d);
        case (d)
            0:       return {8'h00, p0};
            1:       return {4'h0, p1};
            default: return p2;
        endcase
    endfunction

    function automatic logic bget(int d);
        case (d)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic dget(int d);
        case (d)
            0:       return dn0;
            1:       return dn1;
            default: return dn2;
        endcase
    endfunction

    function automatic void check(string name, logic [15:0] act, logic [15:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic void push(int d, logic [15:0] e, int id);
        item_t it;
        it.exp     = e;
        it.edge_no = cyc + 1;
        it.id      = id;
        case (d)
            0:       q0.push_back(it);
            1:       q1.push_back(it);
            default: q2.push_back(it);
        endcase
    endfunction

    // Behavioural product, truncated to M+N bits.
    function automatic logic [15:0] model(int d, logic s, logic [7:0] a, logic [7:0] b);
        int m, n, ia, ib;
        longint pr;
        m  = mw(d);
        n  = nw(d);
        ia = int'(a) & ((1 << m) - 1);
        ib = int'(b) & ((1 << n) - 1);
        if (s) begin
            if (ia >= (1 << (m - 1))) ia = ia - (1 << m);
            if (ib >= (1 << (n - 1))) ib = ib - (1 << n);
        end
        pr = longint'(ia) * longint'(ib);
        return 16'(pr & ((64'sd1 << (m + n)) - 1));
    endfunction

    task automatic drive(int d, logic s, logic [7:0] a, logic [7:0] b, logic st);
        case (d)
            0: begin st0 = st; sg0 = s; a0 = a[3:0]; b0 = b[3:0]; end
            1: begin st1 = st; sg1 = s; a1 = a[3:0]; b1 = b;      end
            default: begin st2 = st; sg2 = s; a2 = a; b2 = b;     end
        endcase
    endtask

    task automatic wait_done(int d);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = dget(d);
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL dut%0d done timeout: no done within 40 cycles, expected one", d);
        end
    endtask

    task automatic op(int d, logic s, logic [7:0] a, logic [7:0] b, logic [15:0] exp, int id);
        @(negedge clk);
        drive(d, s, a, b, 1'b1);
        push(d, exp, id);
        @(posedge clk);
        #1 drive(d, s, a, b, 1'b0);
        check($sformatf("dut%0d op%0d busy after start", d, id), 16'(bget(d)), 16'd1);
        wait_done(d);
    endtask

    task automatic rand_run(int d, int nops);
        for (int i = 0; i < nops; i++) begin
            logic s;
            logic [7:0] a, b;
            s = i[0];
            a = 8'($urandom);
            b = 8'($urandom);
            op(d, s, a, b, model(d, s, a, b), 1000 + i);
        end
    endtask

    // Monitor: every done pops one expectation and checks product, latency and busy.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (dget(d)) begin
                item_t it;
                bit    have;
                have = 1'b1;
                case (d)
                    0:       if (q0.size() == 0) have = 1'b0; else it = q0.pop_front();
                    1:       if (q1.size() == 0) have = 1'b0; else it = q1.pop_front();
                    default: if (q2.size() == 0) have = 1'b0; else it = q2.pop_front();
                endcase
                if (!have) begin
                    nvec++;
                    nerr++;
                    $display("FAIL dut%0d unexpected done: got done with P=%h, expected no done", d, pget(d));
                end else begin
                    check($sformatf("dut%0d op%0d P", d, it.id), pget(d), it.exp);
                    check($sformatf("dut%0d op%0d latency", d, it.id), 16'(cyc - it.edge_no), 16'(nw(d)));
                    check($sformatf("dut%0d op%0d busy at done", d, it.id), 16'(bget(d)), 16'd0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d reset P", d), pget(d), 16'h0);
            check($sformatf("dut%0d reset busy", d), 16'(bget(d)), 16'd0);
            check($sformatf("dut%0d reset done", d), 16'(dget(d)), 16'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 4x4 unsigned and signed directed vectors
        op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 1);
        repeat (3) @(negedge clk);
        check("dut0 P hold", pget(0), 16'h00E1);
        op(0, 1'b1, 8'h08, 8'h07, 16'h00C8, 2);
        op(0, 1'b1, 8'h08, 8'h08, 16'h0040, 3);
        op(0, 1'b1, 8'h0F, 8'h01, 16'h00FF, 4);
        op(0, 1'b1, 8'h07, 8'h09, 16'h00CF, 5);
        op(0, 1'b1, 8'h00, 8'h0F, 16'h0000, 6);

        // 4x8 and 8x8 directed vectors
        op(1, 1'b0, 8'h0D, 8'hC8, 16'h0A28, 7);
        op(1, 1'b1, 8'h0F, 8'h80, 16'h0080, 8);
        op(2, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 9);
        op(2, 1'b1, 8'h80, 8'h80, 16'h4000, 10);
        op(2, 1'b1, 8'h80, 8'h7F, 16'hC080, 11);

        // Back-to-back: start held through busy is ignored, taken when done fires
        @(negedge clk);
        drive(0, 1'b0, 8'h03, 8'h05, 1'b1);
        push(0, 16'h000F, 12);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h09, 8'h09, 1'b1);
        wait_done(0);
        push(0, 16'h0051, 13);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h09, 8'h09, 1'b0);
        check("dut0 b2b second busy", 16'(bget(0)), 16'd1);
        wait_done(0);

        // Asynchronous reset two cycles into a run aborts it
        @(negedge clk);
        drive(0, 1'b0, 8'h05, 8'h05, 1'b1);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h05, 8'h05, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("dut0 abort P", pget(0), 16'h0);
        check("dut0 abort busy", 16'(bget(0)), 16'd0);
        check("dut0 abort done", 16'(dget(0)), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        op(0, 1'b0, 8'h06, 8'h07, 16'h002A, 14);

        // Random regression, both modes interleaved, all three shapes in parallel
        fork
            rand_run(0, 2000);
            rand_run(1, 2000);
            rand_run(2, 2000);
        join

        repeat (5) @(negedge clk);
        check("dut0 queue drained", 16'(q0.size()), 16'd0);
        check("dut1 queue drained", 16'(q1.size()), 16'd0);
        check("dut2 queue drained", 16'(q2.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
